adc_multislope: RTL

Multislope integrating-ADC controller: the responder end of the `adc_measure_trig` / `adc_measure_valid` handshake driven by the acquisition sequencers. On each trigger it resets the integrator, runs a comparator-steered runup over a programmed aperture, then a timed rundown to the zero crossing. It then publishes the up/down/rundown counts and asserts `adc_measure_valid`. It sits between the sequencer and the analog integrator switches and comparator.

---
 rtl/adc_multislope_pkg.sv | 22 ++
 rtl/adc_multislope_sync2.sv | 22 ++
 rtl/adc_multislope.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adc_multislope_pkg.sv
// rtl/adc_multislope_pkg.sv - shared constants and state encoding for the multislope ADC controller
package adc_multislope_pkg;

    // Reference mux codes driven onto the integrator switches; 2'b11 is never produced.
    localparam logic [1:0] REFMUX_OFF = 2'b00;
    localparam logic [1:0] REFMUX_POS = 2'b01;
    localparam logic [1:0] REFMUX_NEG = 2'b10;

    // System clock rate that sequencers use when converting times into clk counts.
    localparam int unsigned CLK_FREQ = 20_000_000;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_RESET         = 3'd1,
        ST_RUNUP_START   = 3'd2,
        ST_RUNUP         = 3'd3,
        ST_RUNDOWN_START = 3'd4,
        ST_RUNDOWN       = 3'd5,
        ST_DONE          = 3'd6
    } state_t;

endpackage

// File: rtl/adc_multislope_sync2.sv
// rtl/adc_multislope_sync2.sv - parameterless two-flop synchronizer for asynchronous inputs
module adc_multislope_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both clear to 0 so the first decision after reset is deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_multislope.sv
// rtl/adc_multislope.sv - multislope integrating ADC controller (runup/rundown sequencer)
module adc_multislope
    import adc_multislope_pkg::*;
#(
    parameter int COUNT_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adc_measure_trig,
    input  logic               cmpr_val,
    input  logic [COUNT_W-1:0] clk_count_reset_n,
    input  logic [COUNT_W-1:0] clk_count_aperture_n,
    input  logic [COUNT_W-1:0] clk_count_var_n,
    output logic               adc_measure_valid,
    output logic               sigmux,
    output logic               resetmux,
    output logic [1:0]         refmux,
    output logic [COUNT_W-1:0] count_up,
    output logic [COUNT_W-1:0] count_down,
    output logic [COUNT_W-1:0] count_rundown,
    output logic               rundown_dir,
    output logic               overflow,
    output logic [1:0]         monitor
);

    localparam logic [COUNT_W-1:0] ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] ALL_ONE = '1;
    localparam logic [COUNT_W-1:0] RD_LAST = ALL_ONE - ONE;

    state_t             state, state_n;
    logic               cmpr_s;
    logic [COUNT_W-1:0] phase, phase_n, aper, aper_n;
    logic [COUNT_W-1:0] up_w, up_wn, down_w, down_wn, rd_cnt, rd_cnt_n;
    logic               rd_dir, rd_dir_n, ovf_w, ovf_wn;
    logic               valid_n, sigmux_n, resetmux_n, rundown_dir_n, overflow_n;
    logic [1:0]         refmux_n;
    logic [COUNT_W-1:0] count_up_n, count_down_n, count_rundown_n;
    logic [COUNT_W-1:0] var_len, aper_dec;

    adc_multislope_sync2 u_cmpr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cmpr_val),
        .q     (cmpr_s)
    );

    // RUNUP phase length is max(var,1)-1 so a full runup cycle is max(var,1)+1 clks with its start cycle.
    assign var_len  = (clk_count_var_n == '0) ? '0 : clk_count_var_n - ONE;
    assign aper_dec = (aper == '0) ? '0 : aper - ONE;
    assign monitor  = {state == ST_RUNDOWN, state == ST_RUNUP};

    // Next-state, counter and output-register decisions; a trigger always wins and restarts at RESET.
    always_comb begin
        state_n         = state;
        phase_n         = phase;
        aper_n          = aper;
        up_wn           = up_w;
        down_wn         = down_w;
        rd_cnt_n        = rd_cnt;
        rd_dir_n        = rd_dir;
        ovf_wn          = ovf_w;
        valid_n         = adc_measure_valid;
        sigmux_n        = sigmux;
        resetmux_n      = resetmux;
        refmux_n        = refmux;
        count_up_n      = count_up;
        count_down_n    = count_down;
        count_rundown_n = count_rundown;
        rundown_dir_n   = rundown_dir;
        overflow_n      = overflow;
        unique case (state)
            ST_IDLE: begin
            end
            ST_RESET: begin
                if (phase <= ONE) begin
                    resetmux_n = 1'b0;
                    sigmux_n   = 1'b1;
                    aper_n     = clk_count_aperture_n;
                    state_n    = ST_RUNUP_START;
                end else begin
                    phase_n = phase - ONE;
                end
            end
            ST_RUNUP_START: begin
                aper_n = aper_dec;
                if (cmpr_s) begin
                    refmux_n = REFMUX_NEG;
                    down_wn  = down_w + ONE;
                end else begin
                    refmux_n = REFMUX_POS;
                    up_wn    = up_w + ONE;
                end
                phase_n = var_len;
                state_n = ST_RUNUP;
            end
            ST_RUNUP: begin
                aper_n = aper_dec;
                if (phase == '0) begin
                    // Aperture is judged after this clk's decrement, so a cycle is never cut short.
                    if (aper <= ONE) begin
                        sigmux_n = 1'b0;
                        state_n  = ST_RUNDOWN_START;
                    end else begin
                        state_n = ST_RUNUP_START;
                    end
                end else begin
                    phase_n = phase - ONE;
                end
            end
            ST_RUNDOWN_START: begin
                rd_dir_n = cmpr_s;
                refmux_n = cmpr_s ? REFMUX_NEG : REFMUX_POS;
                rd_cnt_n = '0;
                state_n  = ST_RUNDOWN;
            end
            ST_RUNDOWN: begin
                if (cmpr_s != rd_dir) begin
                    ovf_wn   = 1'b0;
                    refmux_n = REFMUX_OFF;
                    state_n  = ST_DONE;
                end else begin
                    rd_cnt_n = rd_cnt + ONE;
                    if (rd_cnt == RD_LAST) begin
                        ovf_wn   = 1'b1;
                        refmux_n = REFMUX_OFF;
                        state_n  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                count_up_n      = up_w;
                count_down_n    = down_w;
                count_rundown_n = rd_cnt;
                rundown_dir_n   = rd_dir;
                overflow_n      = ovf_w;
                valid_n         = 1'b1;
                state_n         = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (adc_measure_trig) begin
            valid_n    = 1'b0;
            up_wn      = '0;
            down_wn    = '0;
            rd_cnt_n   = '0;
            ovf_wn     = 1'b0;
            phase_n    = clk_count_reset_n;
            resetmux_n = 1'b1;
            sigmux_n   = 1'b0;
            refmux_n   = REFMUX_OFF;
            state_n    = ST_RESET;
        end
    end

    // FSM state, counters and every output register live in this single clocked block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            phase             <= '0;
            aper              <= '0;
            up_w              <= '0;
            down_w            <= '0;
            rd_cnt            <= '0;
            rd_dir            <= 1'b0;
            ovf_w             <= 1'b0;
            adc_measure_valid <= 1'b0;
            sigmux            <= 1'b0;
            resetmux          <= 1'b0;
            refmux            <= REFMUX_OFF;
            count_up          <= '0;
            count_down        <= '0;
            count_rundown     <= '0;
            rundown_dir       <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            state             <= state_n;
            phase             <= phase_n;
            aper              <= aper_n;
            up_w              <= up_wn;
            down_w            <= down_wn;
            rd_cnt            <= rd_cnt_n;
            rd_dir            <= rd_dir_n;
            ovf_w             <= ovf_wn;
            adc_measure_valid <= valid_n;
            sigmux            <= sigmux_n;
            resetmux          <= resetmux_n;
            refmux            <= refmux_n;
            count_up          <= count_up_n;
            count_down        <= count_down_n;
            count_rundown     <= count_rundown_n;
            rundown_dir       <= rundown_dir_n;
            overflow          <= overflow_n;
        end
    end

endmodule
